// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage_pkg
// Description : Shared constants and types for the MEM->WB pipeline boundary.
//               Default payload widths, WB control bit indices and the
//               occupancy state encoding used by the stage controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_stage_pkg;

    // Default payload field widths
    localparam int CTRL_W_DEF = 2;
    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    // Bit positions inside the WB control field
    localparam int WB_REGWRITE = 0;
    localparam int WB_MEM2REG  = 1;

    // Occupancy encoding; the value is exported directly on the occupancy port
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One payload register of the MEM->WB stage. Clears on rst or
//               clr, otherwise captures d when load is high, else holds.
// Ports       : clk, rst     - clock / synchronous active-high reset
//               clr          - synchronous clear (lower priority than rst)
//               load         - capture enable
//               d / q        - payload in / registered payload out
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
    import mem_wb_stage_pkg::*;
#(
    parameter int WIDTH = CTRL_W_DEF + 2 * DATA_W_DEF + REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM->WB pipeline boundary register with valid/ready handshake,
//               synchronous flush and an optional 2-entry skid buffer.
//               Payload {wb, dm_out, alu_out, write_reg} is carried unchanged.
// Ports       : clk, rst            - clock / synchronous active-high reset
//               flush               - kill all held entries
//               in_valid/in_ready   - upstream handshake
//               in_wb, in_dm_out, in_alu_out, in_write_reg - incoming payload
//               out_valid/out_ready - downstream handshake
//               out_wb, out_dm_out, out_alu_out, out_write_reg - head payload
//               occupancy           - entries held (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_wb,
    input  logic [DATA_W-1:0] in_dm_out,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [REG_W-1:0]  in_write_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_wb,
    output logic [DATA_W-1:0] out_dm_out,
    output logic [DATA_W-1:0] out_alu_out,
    output logic [REG_W-1:0]  out_write_reg,
    output logic [1:0]        occupancy
);

    localparam int c_PAY_W = CTRL_W + 2 * DATA_W + REG_W;

    occ_state_e         r_state;
    occ_state_e         w_state_nxt;
    logic               w_accept;
    logic               w_drain;
    logic               w_head_load;
    logic               w_head_sel_skid;
    logic               w_skid_load;
    logic               w_skid_clr;
    logic [c_PAY_W-1:0] w_in_pay;
    logic [c_PAY_W-1:0] w_head_d;
    logic [c_PAY_W-1:0] w_head_q;
    logic [c_PAY_W-1:0] w_skid_q;

    assign w_in_pay  = {in_wb, in_dm_out, in_alu_out, in_write_reg};
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign w_drain   = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Occupancy state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and slot control. With SKID=0 the accept-without-drain
    // case in ONE cannot occur (in_ready requires out_ready while valid),
    // so the same controller never reaches FULL in that build.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_head_load     = 1'b0;
        w_head_sel_skid = 1'b0;
        w_skid_load     = 1'b0;
        w_skid_clr      = 1'b0;
        if (flush) begin
            // Same-cycle accept is dropped; head payload is left untouched so
            // the data fields keep their last value while invalid.
            w_state_nxt = ST_EMPTY;
            w_skid_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_head_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_head_load = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_skid_load = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        w_state_nxt     = ST_ONE;
                        w_head_load     = 1'b1;
                        w_head_sel_skid = 1'b1;
                        w_skid_clr      = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    assign w_head_d = w_head_sel_skid ? w_skid_q : w_in_pay;

    pipe_slot #(
        .WIDTH (c_PAY_W)
    ) u_head (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .load (w_head_load),
        .d    (w_head_d),
        .q    (w_head_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            // in_ready comes straight from a flop so the backward ready path
            // does not depend on out_ready combinationally.
            logic r_in_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != ST_FULL);
                end
            end

            assign in_ready = r_in_ready;

            pipe_slot #(
                .WIDTH (c_PAY_W)
            ) u_skid (
                .clk  (clk),
                .rst  (rst),
                .clr  (w_skid_clr),
                .load (w_skid_load),
                .d    (w_in_pay),
                .q    (w_skid_q)
            );
        end else begin : g_no_skid
            assign in_ready = out_ready | ~out_valid;
            assign w_skid_q = '0;
        end
    endgenerate

    // A bubble must never write the register file, so wb is gated by valid;
    // the data fields simply show the head register.
    assign out_wb        = out_valid ? w_head_q[c_PAY_W-1 -: CTRL_W] : '0;
    assign out_dm_out    = w_head_q[2*DATA_W+REG_W-1 -: DATA_W];
    assign out_alu_out   = w_head_q[DATA_W+REG_W-1 -: DATA_W];
    assign out_write_reg = w_head_q[REG_W-1:0];
    assign occupancy     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage. Drives a SKID=1 and a
//               SKID=0 instance with the same inputs and compares each against
//               a queue-based reference model of an in-order buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] dm;
        logic [31:0] alu;
        logic [4:0]  rg;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [1:0]  in_wb;
    logic [31:0] in_dm_out;
    logic [31:0] in_alu_out;
    logic [4:0]  in_write_reg;
    logic        out_ready;

    logic        s1_in_ready, s1_valid;
    logic [1:0]  s1_wb, s1_occ;
    logic [31:0] s1_dm, s1_alu;
    logic [4:0]  s1_rg;

    logic        s0_in_ready, s0_valid;
    logic [1:0]  s0_wb, s0_occ;
    logic [31:0] s0_dm, s0_alu;
    logic [4:0]  s0_rg;

    int n_checks = 0;
    int n_errors = 0;

    // Reference models: contents in order, plus the payload last shown
    ent_t q1[$];
    ent_t q0[$];
    ent_t last1;
    ent_t last0;

    mem_wb_stage #(.CTRL_W(2), .DATA_W(32), .REG_W(5), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s1_in_ready),
        .in_wb(in_wb), .in_dm_out(in_dm_out), .in_alu_out(in_alu_out),
        .in_write_reg(in_write_reg),
        .out_valid(s1_valid), .out_ready(out_ready),
        .out_wb(s1_wb), .out_dm_out(s1_dm), .out_alu_out(s1_alu),
        .out_write_reg(s1_rg), .occupancy(s1_occ)
    );

    mem_wb_stage #(.CTRL_W(2), .DATA_W(32), .REG_W(5), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s0_in_ready),
        .in_wb(in_wb), .in_dm_out(in_dm_out), .in_alu_out(in_alu_out),
        .in_write_reg(in_write_reg),
        .out_valid(s0_valid), .out_ready(out_ready),
        .out_wb(s0_wb), .out_dm_out(s0_dm), .out_alu_out(s0_alu),
        .out_write_reg(s0_rg), .occupancy(s0_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ent_t mk(input logic [1:0] wb, input logic [31:0] dm,
                                input logic [31:0] alu, input logic [4:0] rg);
        ent_t e;
        e.wb  = wb;
        e.dm  = dm;
        e.alu = alu;
        e.rg  = rg;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare both instances against their models (inputs already applied)
    task automatic check_all();
        logic v1, v0, r1, r0;
        ent_t e1, e0;
        v1 = (q1.size() > 0);
        v0 = (q0.size() > 0);
        e1 = v1 ? q1[0] : last1;
        e0 = v0 ? q0[0] : last0;
        r1 = (q1.size() < 2);
        r0 = out_ready || (q0.size() == 0);
        chk("s1_valid",    32'(s1_valid),    32'(v1));
        chk("s1_in_ready", 32'(s1_in_ready), 32'(r1));
        chk("s1_occ",      32'(s1_occ),      32'(q1.size()));
        chk("s1_wb",       32'(s1_wb),       v1 ? 32'(e1.wb) : 32'd0);
        chk("s1_dm",       s1_dm,            e1.dm);
        chk("s1_alu",      s1_alu,           e1.alu);
        chk("s1_reg",      32'(s1_rg),       32'(e1.rg));
        chk("s0_valid",    32'(s0_valid),    32'(v0));
        chk("s0_in_ready", 32'(s0_in_ready), 32'(r0));
        chk("s0_occ",      32'(s0_occ),      32'(q0.size()));
        chk("s0_wb",       32'(s0_wb),       v0 ? 32'(e0.wb) : 32'd0);
        chk("s0_dm",       s0_dm,            e0.dm);
        chk("s0_alu",      s0_alu,           e0.alu);
        chk("s0_reg",      32'(s0_rg),       32'(e0.rg));
    endtask

    // Apply the transfers that happen at the coming rising edge
    task automatic advance_models();
        ent_t e;
        logic acc, drn;
        e = mk(in_wb, in_dm_out, in_alu_out, in_write_reg);

        acc = in_valid && (q1.size() < 2);
        drn = (q1.size() > 0) && out_ready;
        if (q1.size() > 0) last1 = q1[0];
        if (rst) begin
            q1.delete();
            last1 = '0;
        end else if (flush) begin
            q1.delete();
        end else begin
            if (drn) void'(q1.pop_front());
            if (acc) q1.push_back(e);
        end

        acc = in_valid && (out_ready || (q0.size() == 0));
        drn = (q0.size() > 0) && out_ready;
        if (q0.size() > 0) last0 = q0[0];
        if (rst) begin
            q0.delete();
            last0 = '0;
        end else if (flush) begin
            q0.delete();
        end else begin
            if (drn) void'(q0.pop_front());
            if (acc) q0.push_back(e);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic v,
                        input ent_t e, input logic ordy);
        @(negedge clk);
        rst          = r;
        flush        = f;
        in_valid     = v;
        in_wb        = e.wb;
        in_dm_out    = e.dm;
        in_alu_out   = e.alu;
        in_write_reg = e.rg;
        out_ready    = ordy;
        #1;
        check_all();
        advance_models();
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b1;
        in_wb        = 2'b01;
        in_dm_out    = 32'h1111;
        in_alu_out   = 32'h2222;
        in_write_reg = 5'd3;
        out_ready    = 1'b0;
        last1        = '0;
        last0        = '0;
        @(posedge clk);

        // Reset held with in_valid high
        step(1, 0, 1, mk(2'b01, 32'h1111, 32'h2222, 5'd3), 0);
        step(1, 0, 1, mk(2'b01, 32'h1111, 32'h2222, 5'd3), 0);
        chk("rst_occ", 32'(s1_occ), 32'd0);
        step(0, 0, 0, mk(2'b00, 32'h0, 32'h0, 5'd0), 1);
        chk("post_rst_in_ready", 32'(s1_in_ready), 32'd1);

        // Streaming with downstream always ready
        step(0, 0, 1, mk(2'b01, 32'h100, 32'h10, 5'd5), 1);
        step(0, 0, 1, mk(2'b01, 32'h200, 32'h20, 5'd6), 1);
        chk("stream_alu0", s1_alu, 32'h10);
        step(0, 0, 1, mk(2'b01, 32'h300, 32'h30, 5'd7), 1);
        chk("stream_alu1", s1_alu, 32'h20);
        step(0, 0, 0, mk(2'b00, 32'h0, 32'h0, 5'd0), 1);
        chk("stream_alu2", s1_alu, 32'h30);
        step(0, 0, 0, mk(2'b00, 32'h0, 32'h0, 5'd0), 1);

        // Backpressure: A, B fill the skid; C waits for in_ready
        step(0, 0, 1, mk(2'b11, 32'hA0, 32'hA, 5'd10), 0);
        step(0, 0, 1, mk(2'b11, 32'hB0, 32'hB, 5'd11), 0);
        chk("s0_stall_in_ready", 32'(s0_in_ready), 32'd0);
        step(0, 0, 1, mk(2'b11, 32'hC0, 32'hC, 5'd12), 0);
        chk("bp_occ_full", 32'(s1_occ), 32'd2);
        chk("bp_in_ready", 32'(s1_in_ready), 32'd0);
        step(0, 0, 1, mk(2'b11, 32'hC0, 32'hC, 5'd12), 0);
        step(0, 0, 1, mk(2'b11, 32'hC0, 32'hC, 5'd12), 1);
        chk("s0_release_in_ready", 32'(s0_in_ready), 32'd1);
        chk("bp_head_a", s1_alu, 32'hA);
        step(0, 0, 1, mk(2'b11, 32'hC0, 32'hC, 5'd12), 1);
        chk("bp_head_b", s1_alu, 32'hB);
        step(0, 0, 0, mk(2'b00, 32'h0, 32'h0, 5'd0), 1);
        chk("bp_head_c", s1_alu, 32'hC);
        step(0, 0, 0, mk(2'b00, 32'h0, 32'h0, 5'd0), 1);

        // Flush with skid full and a simultaneous incoming entry
        step(0, 0, 1, mk(2'b01, 32'h51, 32'h5151, 5'd1), 0);
        step(0, 0, 1, mk(2'b01, 32'h52, 32'h5252, 5'd2), 0);
        step(0, 1, 1, mk(2'b11, 32'hDEAD, 32'hDEAD, 5'd31), 0);
        step(0, 0, 0, mk(2'b00, 32'h0, 32'h0, 5'd0), 0);
        chk("flush_valid", 32'(s1_valid), 32'd0);
        chk("flush_occ", 32'(s1_occ), 32'd0);
        chk("flush_wb", 32'(s1_wb), 32'd0);
        chk("flush_no_dead", 32'(s1_alu != 32'hDEAD), 32'd1);
        step(0, 0, 0, mk(2'b00, 32'h0, 32'h0, 5'd0), 1);

        // rst and flush together with one entry held
        step(0, 0, 1, mk(2'b10, 32'h77, 32'h88, 5'd9), 0);
        step(1, 1, 1, mk(2'b11, 32'h99, 32'h99, 5'd8), 0);
        step(0, 0, 0, mk(2'b00, 32'h0, 32'h0, 5'd0), 0);
        chk("rstflush_alu", s1_alu, 32'd0);
        chk("rstflush_occ", 32'(s0_occ), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 2) != 0),
                 mk(2'($urandom), $urandom, $urandom, 5'($urandom)),
                 ($urandom_range(0, 2) != 0));
        end
        step(0, 0, 0, mk(2'b00, 32'h0, 32'h0, 5'd0), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
